// File: rtl/uart_tx_model.sv
// Testbench UART transmitter: byte FIFO feeding an async serializer (start, LSB-first data, stop).
// Optional even-parity bit after the data bits when UART_TX_MODEL_PARITY_EN is defined.
//
// state  | meaning
// IDLE   | line high, waiting for uart_tx_en and a queued byte
// START  | start bit (low) for one bit period
// DATA   | PAYLOAD_BITS data bits, LSB first
// PARITY | even-parity bit (parity build only)
// STOP   | STOP_BITS high bit periods, tx_done on the final cycle
module uart_tx_model #(
  parameter int BIT_RATE     = 9600,
  parameter int CLK_HZ       = 50_000_000,
  parameter int PAYLOAD_BITS = 8,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          resetn,
  output logic                          uart_txd,
  input  logic                          uart_tx_en,
  input  logic [PAYLOAD_BITS-1:0]       tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          tx_busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CPB   = CLK_HZ / BIT_RATE;
  localparam int TMR_W = $clog2(CPB);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(CPB - 1);
  localparam logic [PTR_W:0]   CNT_FULL   = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [3:0]       LAST_DATA  = 4'(PAYLOAD_BITS - 1);
  localparam logic [3:0]       LAST_STOP  = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_MODEL_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t                  state_q, state_d;
  logic [TMR_W-1:0]        tmr_q, tmr_d;
  logic [3:0]              bit_cnt_q, bit_cnt_d;
  logic [PAYLOAD_BITS-1:0] shift_q, shift_d;
  logic                    txd_q, txd_d;
`ifdef UART_TX_MODEL_PARITY_EN
  logic                    par_q, par_d;
`endif

  logic [PAYLOAD_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]          count_q;
  logic                    push, pop;
  logic                    tmr_zero;

  assign tx_ready   = (count_q != CNT_FULL);
  assign push       = tx_valid && tx_ready;
  assign fifo_count = count_q;
  assign uart_txd   = txd_q;
  assign tx_busy    = (state_q != S_IDLE);
  assign tmr_zero   = (tmr_q == '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= tx_data;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      tmr_q     <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      txd_q     <= 1'b1;
`ifdef UART_TX_MODEL_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      txd_q     <= txd_d;
`ifdef UART_TX_MODEL_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_zero ? tmr_q : tmr_q - 1'b1;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    txd_d     = txd_q;
`ifdef UART_TX_MODEL_PARITY_EN
    par_d     = par_q;
`endif
    pop       = 1'b0;
    tx_done   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        txd_d = 1'b1;
        if (uart_tx_en && (count_q != '0)) begin
          pop     = 1'b1;
          shift_d = mem[rd_ptr_q];
`ifdef UART_TX_MODEL_PARITY_EN
          par_d   = ^mem[rd_ptr_q];
`endif
          txd_d   = 1'b0;
          tmr_d   = TMR_RELOAD;
          state_d = S_START;
        end
      end
      S_START: begin
        if (tmr_zero) begin
          state_d   = S_DATA;
          txd_d     = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_cnt_d = '0;
          tmr_d     = TMR_RELOAD;
        end
      end
      S_DATA: begin
        if (tmr_zero) begin
          tmr_d = TMR_RELOAD;
          if (bit_cnt_q == LAST_DATA) begin
            bit_cnt_d = '0;
`ifdef UART_TX_MODEL_PARITY_EN
            state_d   = S_PARITY;
            txd_d     = par_q;
`else
            state_d   = S_STOP;
            txd_d     = 1'b1;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            txd_d     = shift_q[0];
            shift_d   = shift_q >> 1;
          end
        end
      end
`ifdef UART_TX_MODEL_PARITY_EN
      S_PARITY: begin
        if (tmr_zero) begin
          state_d   = S_STOP;
          txd_d     = 1'b1;
          bit_cnt_d = '0;
          tmr_d     = TMR_RELOAD;
        end
      end
`endif
      S_STOP: begin
        txd_d = 1'b1;
        // Last stop cycle: flag completion; the IDLE cycle that follows is the inter-frame gap.
        if (tmr_zero) begin
          if (bit_cnt_q == LAST_STOP) begin
            tx_done = 1'b1;
            state_d = S_IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            tmr_d     = TMR_RELOAD;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        txd_d   = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_model.sv
// Directed bench for uart_tx_model at 10 clocks/bit with a line-decoding monitor.
// Define UART_TX_MODEL_PARITY_EN for both files to exercise the parity build.
module tb_uart_tx_model;

  localparam int CPB = 10;
  localparam int PB  = 8;
`ifdef UART_TX_MODEL_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       uart_tx_en = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       uart_txd, tx_ready, tx_busy, tx_done;
  logic [4:0] fifo_count;

  uart_tx_model #(
    .BIT_RATE(100), .CLK_HZ(1000), .PAYLOAD_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(16)
  ) dut (
    .clk(clk), .resetn(resetn), .uart_txd(uart_txd), .uart_tx_en(uart_tx_en),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_busy(tx_busy),
    .tx_done(tx_done), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // line monitor: decodes frames sampled mid-bit on the falling clock edge
  int         sample_idx = 0;
  bit         in_frame = 1'b0;
  int         mon_pos = 0;
  int         mon_bit = 0;
  logic [7:0] mon_byte = 8'h00;
  int         last_end = -1000;
  int         done_cnt = 0;
  logic [7:0] rx_q[$];
  int         gap_q[$];
  logic       par_bits[$];

  always @(negedge clk) begin
    sample_idx++;
    if (tx_done) done_cnt++;
    if (!resetn) begin
      in_frame = 1'b0;
    end else begin
      if (!in_frame && uart_txd == 1'b0) begin
        in_frame = 1'b1;
        mon_pos  = 0;
        gap_q.push_back(sample_idx - last_end - 1);
      end
      if (in_frame) begin
        if (mon_pos % CPB == CPB / 2) begin
          mon_bit = mon_pos / CPB;
          if (mon_bit == 0) check_val("mon_start_bit", uart_txd, 0);
          else if (mon_bit <= PB) mon_byte[mon_bit-1] = uart_txd;
          else if (mon_bit == FRAME_BITS - 1) check_val("mon_stop_bit", uart_txd, 1);
          else par_bits.push_back(uart_txd);
        end
        if (mon_pos == FRAME_BITS * CPB - 1) begin
          check_val("mon_done_at_frame_end", tx_done, 1);
          in_frame = 1'b0;
          rx_q.push_back(mon_byte);
          last_end = sample_idx;
        end
        mon_pos++;
      end
    end
  end

  task automatic push(input logic [7:0] b);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_rx(input int n, input int budget);
    for (int i = 0; i < budget && rx_q.size() < n; i++) @(negedge clk);
  endtask

  function automatic logic exp_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= PB) return b[k-1];
    if (k < FRAME_BITS - 1) return ^b;
    return 1'b1;
  endfunction

  logic [9:0]  seg;
  int          done_at;
  int          d0;
  int          r0;
  int          lows;
  string       txt;
  logic [7:0]  hi_bytes [3];

  initial begin
    hi_bytes[0] = 8'h48; hi_bytes[1] = 8'h49; hi_bytes[2] = 8'h0a;
    repeat (3) @(negedge clk);
    check_val("rst_txd", uart_txd, 1);
    check_val("rst_ready", tx_ready, 1);
    check_val("rst_busy", tx_busy, 0);
    check_val("rst_done", tx_done, 0);
    check_val("rst_count", fifo_count, 0);
    resetn = 1'b1;
    @(negedge clk);

    // single byte 0x55
    d0 = done_cnt;
    rx_q.delete();
    uart_tx_en = 1'b1;
    push(8'h55);
    done_at = -1;
    for (int k = 0; k < FRAME_BITS; k++) begin
      for (int s = 0; s < CPB; s++) begin
        @(negedge clk);
        seg[s] = uart_txd;
        if (tx_done) done_at = k * CPB + s;
      end
      check_val($sformatf("single_bit%0d", k), seg, exp_bit(8'h55, k) ? 10'h3ff : 10'h000);
    end
    check_val("single_done_offset", done_at, FRAME_BITS * CPB - 1);
    @(negedge clk);
    check_val("single_busy_after", tx_busy, 0);
    check_val("single_txd_after", uart_txd, 1);
    check_val("single_done_count", done_cnt - d0, 1);

    // back-to-back "HI\n"
    repeat (5) @(negedge clk);
    rx_q.delete();
    gap_q.delete();
    d0 = done_cnt;
    for (int i = 0; i < 3; i++) push(hi_bytes[i]);
    wait_rx(3, 500);
    check_val("hi_rx_count", rx_q.size(), 3);
    if (rx_q.size() == 3) begin
      txt = "";
      for (int i = 0; i < 3; i++) begin
        check_val($sformatf("hi_byte%0d", i), rx_q[i], hi_bytes[i]);
        if (rx_q[i] != 8'h0a) txt = $sformatf("%s%c", txt, rx_q[i]);
      end
      $display("TB_UART: %s", txt);
    end
    @(negedge clk);
    check_val("hi_done_count", done_cnt - d0, 3);
    check_val("hi_gap_count", gap_q.size(), 3);
    if (gap_q.size() == 3) begin
      check_val("hi_gap1", gap_q[1], 1);
      check_val("hi_gap2", gap_q[2], 1);
    end

    // FIFO full with transmitter disabled
    uart_tx_en = 1'b0;
    repeat (3) @(negedge clk);
    rx_q.delete();
    for (int i = 0; i < 17; i++) begin
      push(8'(i));
      if (i == 14) check_val("full_ready_at15", tx_ready, 1);
      if (i == 15) begin
        check_val("full_ready_at16", tx_ready, 0);
        check_val("full_count_at16", fifo_count, 16);
      end
    end
    check_val("full_count_after17", fifo_count, 16);
    check_val("full_no_tx_while_disabled", rx_q.size(), 0);
    uart_tx_en = 1'b1;
    wait_rx(16, 2200);
    check_val("full_rx_count", rx_q.size(), 16);
    for (int i = 0; i < 16 && i < rx_q.size(); i++)
      check_val($sformatf("full_byte%0d", i), rx_q[i], 8'(i));
    repeat (200) @(negedge clk);
    check_val("full_no_extra_byte", rx_q.size(), 16);
    check_val("full_count_drained", fifo_count, 0);

    // enable gating mid-frame
    rx_q.delete();
    d0 = done_cnt;
    push(8'hA1); push(8'hB2); push(8'hC3);
    repeat (25) @(negedge clk);
    check_val("gate_busy_in_data", tx_busy, 1);
    uart_tx_en = 1'b0;
    for (int i = 0; i < 200 && done_cnt == d0; i++) @(negedge clk);
    check_val("gate_frame1_done", done_cnt - d0, 1);
    repeat (40) @(negedge clk);
    check_val("gate_rx_one", rx_q.size(), 1);
    check_val("gate_count_held", fifo_count, 2);
    check_val("gate_idle_txd", uart_txd, 1);
    check_val("gate_idle_busy", tx_busy, 0);
    uart_tx_en = 1'b1;
    wait_rx(3, 400);
    check_val("gate_rx_count", rx_q.size(), 3);
    if (rx_q.size() == 3) begin
      check_val("gate_byte0", rx_q[0], 8'hA1);
      check_val("gate_byte1", rx_q[1], 8'hB2);
      check_val("gate_byte2", rx_q[2], 8'hC3);
    end
    check_val("gate_count_final", fifo_count, 0);

    // reset in bit 3 of a frame with 4 bytes queued
    repeat (5) @(negedge clk);
    uart_tx_en = 1'b0;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    check_val("rstmid_count_queued", fifo_count, 4);
    uart_tx_en = 1'b1;
    repeat (36) @(negedge clk);
    check_val("rstmid_busy_before", tx_busy, 1);
    d0 = done_cnt;
    r0 = rx_q.size();
    #2 resetn = 1'b0;
    #1;
    check_val("rstmid_txd", uart_txd, 1);
    check_val("rstmid_count", fifo_count, 0);
    check_val("rstmid_ready", tx_ready, 1);
    check_val("rstmid_done", tx_done, 0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    lows = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (uart_txd == 1'b0) lows++;
    end
    check_val("rstmid_idle_lows", lows, 0);
    check_val("rstmid_no_done", done_cnt - d0, 0);
    check_val("rstmid_no_rx", rx_q.size(), r0);

`ifdef UART_TX_MODEL_PARITY_EN
    rx_q.delete();
    par_bits.delete();
    push(8'h07); push(8'h03);
    wait_rx(2, 400);
    check_val("par_rx_count", par_bits.size(), 2);
    if (par_bits.size() == 2) begin
      check_val("par_bit_07", par_bits[0], 1);
      check_val("par_bit_03", par_bits[1], 0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_model.md
Name: uart_tx_model

Overview:
Testbench UART transmitter. It is the companion to the co-sim UART receiver model and drives serial text into the DUT UART RX pin. C-side or testbench tasks push bytes through a valid/ready interface into a small FIFO. The block serializes each byte as an asynchronous frame (start, data LSB-first, stop) at a fixed bit rate. It sits in the cep_cosim testbench top, alongside the receiver model, on the DUT rxd pin.

Parameters:
BIT_RATE, 9600, serial bit rate in bits/s
CLK_HZ, 50_000_000, clk frequency in Hz; CYCLES_PER_BIT = CLK_HZ/BIT_RATE, integer truncation, must be >= 2
PAYLOAD_BITS, 8, data bits per frame (5..8)
STOP_BITS, 1, stop bits per frame (1 or 2)
FIFO_DEPTH, 16, byte FIFO entries (power of 2, >= 2)

Ports:
clk  input  1  testbench clock
resetn  input  1  reset
uart_txd  output  1  serial line to DUT rxd; idle high
uart_tx_en  input  1  1 = allowed to start new frames
tx_data  input  PAYLOAD_BITS  byte to queue
tx_valid  input  1  push request
tx_ready  output  1  FIFO not full; a push is accepted when tx_valid && tx_ready at posedge clk
tx_busy  output  1  1 while a frame is in START/DATA/PARITY/STOP
tx_done  output  1  one-cycle pulse at the end of each frame's last stop bit
fifo_count  output  $clog2(FIFO_DEPTH)+1  bytes queued, excluding the frame in flight

Interface decision: one clock; reset is asynchronous and active-low (clk, resetn).

Behaviour:
- Reset values, applied immediately when resetn falls: uart_txd=1, tx_ready=1, tx_busy=0, tx_done=0, fifo_count=0, state=IDLE. FIFO pointers cleared and contents discarded.
- FIFO ordering and capacity: FIFO is first-in first-out. tx_ready = (fifo_count != FIFO_DEPTH), taken from registered count only.
  - A push while full is ignored (no overwrite).
  - On a cycle with a push and a pop together, fifo_count is unchanged.
- Bit timer: down-counter reloaded with CYCLES_PER_BIT-1 on every state or bit transition. Each serial bit lasts exactly CYCLES_PER_BIT clocks.
- State machine:
  - IDLE: uart_txd=1. If uart_tx_en && fifo_count!=0, pop the head into the shift register, go to START, and drive uart_txd=0 on that edge.
  - START: hold 0 for CYCLES_PER_BIT cycles, then go to DATA.
  - DATA: drive shift[0], shift right each bit period, run PAYLOAD_BITS periods. Then go to PARITY if the parity feature is enabled, else to STOP.
  - PARITY: one bit period (see Optional Feature).
  - STOP: uart_txd=1 for STOP_BITS*CYCLES_PER_BIT cycles. On the last cycle assert tx_done for one clock, then go to IDLE.
- Frame spacing: back-to-back frames have exactly one IDLE clock (txd high) between the last stop cycle and the next start bit.
- Latency: push accepted at edge N into an empty FIFO with uart_tx_en=1 → uart_txd goes low after edge N+1.
- tx_busy=1 in every state except IDLE.
- uart_tx_en deasserted mid-frame: the current frame completes normally and no further frame starts. Queued bytes stay and fifo_count holds.
- Reset mid-frame: line returns high at once and the partial frame is abandoned. No tx_done is generated.
- Pushes during a frame are accepted normally up to the FIFO limit.

Optional Feature:
Macro UART_TX_MODEL_PARITY_EN.
- Defined: one even-parity bit (XOR of the PAYLOAD_BITS data bits) is sent after the data bits for one bit period. Frame length is 1+PAYLOAD_BITS+1+STOP_BITS bit periods.
- Undefined: no PARITY state is built. Frame length is 1+PAYLOAD_BITS+STOP_BITS bit periods.

Test Plan:
- Single byte: CLK_HZ=1000, BIT_RATE=100 (10 cycles/bit), push 0x55, en=1.
  - uart_txd reads 0,1,0,1,0,1,0,1,0,1 (start, then data LSB-first, then stop), each held 10 clocks.
  - tx_done pulses once 100 clocks after txd first falls; tx_busy=0 afterwards.
- Loopback: connect uart_txd to the receiver model (same parameters) and push "HI\n" (0x48, 0x49, 0x0a).
  - Receiver logs "TB_UART: HI" and three tx_done pulses are observed.
  - Exactly one idle-high clock appears between frames.
- FIFO full: en=0, push 17 bytes (0x00..0x10) on consecutive cycles.
  - tx_ready falls after the 16th is accepted and fifo_count=16.
  - Set en=1: bytes 0x00..0x0F are transmitted in order and 0x10 is never sent.
- Enable gating: queue 3 bytes, then drop en during frame 1's DATA phase.
  - Frame 1 completes with tx_done, no second start bit follows, and fifo_count=2.
  - Re-raise en: the remaining two frames are sent.
- Reset mid-frame: assert resetn=0 in bit 3 of frame 1 with 4 bytes queued.
  - uart_txd=1 within the same timestep, fifo_count=0, tx_ready=1, no tx_done.
  - After release with no pushes, the line stays idle for 200 clocks.
- Parity build (UART_TX_MODEL_PARITY_EN): push 0x07, then 0x03.
  - Parity bits are 1 and 0 respectively.
  - Each frame is 11 bit periods; with the macro undefined, frames are 10 bit periods.
